// File: rtl/event_latch_ctrl.sv
// ============================================================================
// event_latch_ctrl : synchronise, edge-detect and latch events; hand a stable
//                    snapshot and save request to the UFM event-save writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module event_latch_ctrl #(
  parameter int GPI_BIT     = 512,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_MS  = 10,
  parameter int TIMEOUT_MS  = 1000
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic [GPI_BIT-1:0] evt_i,
  input  logic [GPI_BIT-1:0] evt_mask_i,
  input  logic               tick_1ms_i,
  input  logic               clear_i,
  input  logic               save_busy_i,
  input  logic               save_done_i,
  output logic [GPI_BIT-1:0] gpi_o,
  output logic               save_req_o,
  output logic               evt_pending_o,
  output logic [15:0]        save_cnt_o,
  output logic               timeout_o
);

  localparam int HW = (HOLDOFF_MS > 0) ? $clog2(HOLDOFF_MS + 1) : 1;
  localparam int TW = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_holdoff = 2'd1;
  localparam logic [1:0] c_st_req     = 2'd2;
  localparam logic [1:0] c_st_wait    = 2'd3;

  logic [SYNC_STAGES-1:0][GPI_BIT-1:0] sync_q, sync_d;
  logic [GPI_BIT-1:0] prev_q, latch_q, latch_d, gpi_q, gpi_d;
  logic [1:0]         state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      to_q, to_d;
  logic               req_q, req_d, pending_q, pending_d;
  logic               timeout_q, timeout_d, clr_pend_q, clr_pend_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [GPI_BIT-1:0] w_rise, w_new;
  logic               w_go_idle;

  always_comb begin
    sync_d[0] = evt_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign w_rise = sync_q[SYNC_STAGES-1] & ~prev_q & evt_mask_i;
  assign w_new  = latch_q & ~gpi_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    to_d       = to_q;
    gpi_d      = gpi_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q;
    timeout_d  = clear_i ? 1'b0 : timeout_q;
    // A rise coincident with clear survives into the fresh log.
    latch_d    = clear_i ? w_rise : (latch_q | w_rise);
    pending_d  = clear_i ? 1'b0 : (|w_new);
    w_go_idle  = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (clear_i) begin
          gpi_d = '0;
        end else if (pending_q) begin
          if (HOLDOFF_MS > 0) begin
            state_d = c_st_holdoff;
            hold_d  = HW'(HOLDOFF_MS);
          end else begin
            state_d = c_st_req;
            gpi_d   = latch_q;
            req_d   = 1'b1;
            to_d    = TW'(TIMEOUT_MS);
          end
        end
      end
      c_st_holdoff: begin
        if (clear_i) begin
          gpi_d   = '0;
          state_d = c_st_idle;
        end else if (tick_1ms_i) begin
          if (hold_q == HW'(1)) begin
            state_d = c_st_req;
            gpi_d   = latch_q;
            req_d   = 1'b1;
            to_d    = TW'(TIMEOUT_MS);
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
      default: begin
        // REQ / WAIT_DONE: the handshake always runs to completion or timeout.
        if (clear_i) clr_pend_d = 1'b1;
        if (save_done_i) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          w_go_idle = 1'b1;
        end else if (state_q == c_st_req && save_busy_i) begin
          state_d = c_st_wait;
          req_d   = 1'b0;
        end else if (tick_1ms_i) begin
          if (to_q == TW'(1)) begin
            timeout_d = 1'b1;
            w_go_idle = 1'b1;
          end else begin
            to_d = to_q - TW'(1);
          end
        end
        if (w_go_idle) begin
          state_d    = c_st_idle;
          req_d      = 1'b0;
          clr_pend_d = 1'b0;
          if (clr_pend_q || clear_i) gpi_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync_q     <= '0;
      prev_q     <= '0;
      latch_q    <= '0;
      gpi_q      <= '0;
      state_q    <= c_st_idle;
      hold_q     <= '0;
      to_q       <= '0;
      req_q      <= 1'b0;
      pending_q  <= 1'b0;
      timeout_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= sync_q[SYNC_STAGES-1];
      latch_q    <= latch_d;
      gpi_q      <= gpi_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      to_q       <= to_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
      timeout_q  <= timeout_d;
      clr_pend_q <= clr_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gpi_o         = gpi_q;
  assign save_req_o    = req_q;
  assign evt_pending_o = pending_q;
  assign save_cnt_o    = cnt_q;
  assign timeout_o     = timeout_q;

endmodule

`default_nettype wire
